// File: rtl/ad5628_cmd_seq.sv
// ad5628_cmd_seq: builds AD5628 command words (reset, reference, per-channel
// write-and-update) and feeds them to the SPI serializer over valid/ready.
module ad5628_cmd_seq #(
    parameter bit          INT_REF      = 1'b1,
    parameter logic [11:0] CH_INIT_CODE = 12'h800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ch_wr_en,
    input  logic [2:0]  ch_wr_addr,
    input  logic [11:0] ch_wr_data,
    output logic        cmd_valid,
    output logic [31:0] cmd_data,
    input  logic        cmd_ready,
    output logic        busy,
    output logic        init_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_RST = 3'd1,
        SEND_REF = 3'd2,
        SEND_CH  = 3'd3,
        RUN_IDLE = 3'd4
    } state_t;

    localparam logic [31:0] RESET_WORD = 32'h0700_0000;
    localparam logic [31:0] REF_WORD   = 32'h0800_0001;

    state_t      state, state_n;
    logic        gap, gap_n;
    logic [2:0]  ch, ch_n;
    logic        in_init, in_init_n;
    logic [31:0] data_n;
    logic        done_n;
    logic [11:0] code [8];
    logic [7:0]  dirty;
    logic        accept;
    logic        clr_en;
    logic [2:0]  lowest;

    function automatic logic [31:0] ch_word(input logic [2:0] n, input logic [11:0] c);
        return {4'h0, 4'h3, 1'b0, n, c, 8'h00};
    endfunction

    assign cmd_valid = (state == SEND_RST || state == SEND_REF || state == SEND_CH) && !gap;
    assign busy      = (state == SEND_RST || state == SEND_REF || state == SEND_CH);
    assign accept    = cmd_valid && cmd_ready;
    assign clr_en    = (state == SEND_CH) && accept;

    always_comb begin
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (dirty[i]) lowest = i[2:0];
        end
    end

    always_comb begin
        state_n   = state;
        gap_n     = gap;
        ch_n      = ch;
        in_init_n = in_init;
        data_n    = cmd_data;
        done_n    = init_done;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SEND_RST;
                    gap_n     = 1'b0;
                    in_init_n = 1'b1;
                    data_n    = RESET_WORD;
                end
            end
            SEND_RST, SEND_REF, SEND_CH: begin
                if (!gap) begin
                    if (accept) begin
                        gap_n = 1'b1;
                        if (state == SEND_CH && in_init && ch == 3'd7) done_n = 1'b1;
                    end
                end else begin
                    // Gap cycle over: pick and latch the next word.
                    gap_n = 1'b0;
                    if (state == SEND_RST && INT_REF) begin
                        state_n = SEND_REF;
                        data_n  = REF_WORD;
                    end else if (state == SEND_RST || state == SEND_REF) begin
                        state_n = SEND_CH;
                        ch_n    = 3'd0;
                        data_n  = ch_word(3'd0, code[0]);
                    end else if (in_init && ch != 3'd7) begin
                        ch_n   = ch + 3'd1;
                        data_n = ch_word(ch + 3'd1, code[ch + 3'd1]);
                    end else begin
                        state_n   = RUN_IDLE;
                        in_init_n = 1'b0;
                    end
                end
            end
            RUN_IDLE: begin
                if (|dirty) begin
                    state_n = SEND_CH;
                    gap_n   = 1'b0;
                    ch_n    = lowest;
                    data_n  = ch_word(lowest, code[lowest]);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gap       <= 1'b0;
            ch        <= 3'd0;
            in_init   <= 1'b0;
            cmd_data  <= 32'h0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            gap       <= gap_n;
            ch        <= ch_n;
            in_init   <= in_init_n;
            cmd_data  <= data_n;
            init_done <= done_n;
        end
    end

    // A write on the acceptance edge wins over the clear so the new code is resent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirty <= 8'h00;
            for (int i = 0; i < 8; i++) code[i] <= CH_INIT_CODE;
        end else begin
            if (ch_wr_en) code[ch_wr_addr] <= ch_wr_data;
            for (int i = 0; i < 8; i++) begin
                if (ch_wr_en && ch_wr_addr == 3'(i)) dirty[i] <= 1'b1;
                else if (clr_en && ch == 3'(i))      dirty[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ad5628_cmd_seq.sv
// Self-checking bench for ad5628_cmd_seq: table-driven init sequence, hand-written
// corner cases, and a randomized run checked against a pending-channel model.
module tb_ad5628_cmd_seq;

    logic        clk = 1'b0;
    logic        rst, start, ch_wr_en, cmd_ready;
    logic [2:0]  ch_wr_addr;
    logic [11:0] ch_wr_data;
    logic        cmd_valid, busy, init_done;
    logic [31:0] cmd_data;

    ad5628_cmd_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr), .ch_wr_data(ch_wr_data),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .busy(busy), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] word;
        int          stall;
        int          exp_wait;
        bit          wr_during;
    } vec_t;

    vec_t init_tbl[10];

    // Waits for a word, stalls it, accepts it, and checks the following gap cycle.
    task automatic expect_word(input string name, input logic [31:0] exp, input int stall,
                               input int exp_wait, input bit wr_during,
                               input bit coll, input logic [11:0] cdata);
        int n = 0;
        cmd_ready = 1'b0;
        while (!cmd_valid && n < 30) begin
            tick();
            n++;
        end
        if (!cmd_valid) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: cmd_valid=0 after 30 cycles, required 1", name);
            return;
        end
        if (exp_wait >= 0) chk({name, " latency"}, n, exp_wait);
        for (int s = 0; s < stall; s++) begin
            chk({name, " stall data"}, cmd_data, exp);
            chk({name, " stall valid"}, {31'h0, cmd_valid}, 32'h1);
            if (wr_during && s < 2) begin
                ch_wr_en   = 1'b1;
                ch_wr_addr = (s == 0) ? 3'd5 : 3'd2;
                ch_wr_data = (s == 0) ? 12'h123 : 12'hABC;
            end
            tick();
            ch_wr_en = 1'b0;
        end
        chk(name, cmd_data, exp);
        chk({name, " busy"}, {31'h0, busy}, 32'h1);
        cmd_ready = 1'b1;
        if (coll) begin
            ch_wr_en   = 1'b1;
            ch_wr_addr = 3'd3;
            ch_wr_data = cdata;
        end
        tick();
        cmd_ready = 1'b0;
        ch_wr_en  = 1'b0;
        chk({name, " gap"}, {31'h0, cmd_valid}, 32'h0);
    endtask

    // Reference model for the random phase: a channel owes a word once written,
    // and the owed word is discharged by an acceptance not colliding with a write.
    bit          model_en = 1'b0;
    logic [11:0] mcode     [8];
    logic [11:0] last_sent [8];
    bit          pend      [8];
    bit          written   [8];

    always @(negedge clk) begin
        if (model_en) begin
            if (cmd_valid && cmd_ready) begin
                int n;
                n = int'(cmd_data[22:20]);
                chk("rand word format", {15'h0, cmd_data[31:23], cmd_data[7:0]}, {15'h0, 9'h006, 8'h00});
                chk("rand word owed", {31'h0, pend[n]}, 32'h1);
                last_sent[n] = cmd_data[19:8];
                if (!(ch_wr_en && int'(ch_wr_addr) == n)) pend[n] = 1'b0;
            end
            if (ch_wr_en) begin
                mcode[ch_wr_addr]   = ch_wr_data;
                pend[ch_wr_addr]    = 1'b1;
                written[ch_wr_addr] = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst = 1'b1; start = 1'b0; ch_wr_en = 1'b0; ch_wr_addr = 3'd0;
        ch_wr_data = 12'h0; cmd_ready = 1'b0;

        init_tbl[0] = '{32'h0700_0000, 0, 0, 1'b0};
        init_tbl[1] = '{32'h0800_0001, 5, 1, 1'b0};
        for (int i = 0; i < 8; i++)
            init_tbl[i + 2] = '{32'h0308_0000 | (i << 20), (i == 7) ? 3 : 0, 1, i == 7};

        // Reset and idle
        tick(); tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("reset cmd_valid", {31'h0, cmd_valid}, 32'h0);
        chk("reset cmd_data", cmd_data, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset init_done", {31'h0, init_done}, 32'h0);

        // Start ignored mid-init, then reset mid-word
        start = 1'b1; tick(); start = 1'b0;
        expect_word("p1 RESET", 32'h0700_0000, 0, 0, 1'b0, 1'b0, 12'h0);
        start = 1'b1; tick(); start = 1'b0;
        expect_word("p1 REF_ON", 32'h0800_0001, 1, 0, 1'b0, 1'b0, 12'h0);
        expect_word("p1 CH0", 32'h0308_0000, 0, 1, 1'b0, 1'b0, 12'h0);
        tick();
        chk("p1 CH1 in flight", cmd_data, 32'h0318_0000);
        rst = 1'b1;
        #2;
        chk("midrst cmd_valid", {31'h0, cmd_valid}, 32'h0);
        chk("midrst cmd_data", cmd_data, 32'h0);
        chk("midrst busy", {31'h0, busy}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst init_done", {31'h0, init_done}, 32'h0);

        // Full init from the table, with backpressure and writes during CH7 stall
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) chk("init_done before CH7", {31'h0, init_done}, 32'h0);
            expect_word($sformatf("init word %0d", i), init_tbl[i].word, init_tbl[i].stall,
                        init_tbl[i].exp_wait, init_tbl[i].wr_during, 1'b0, 12'h0);
        end
        chk("init_done after CH7", {31'h0, init_done}, 32'h1);

        // Channels dirtied during init go out lowest-first
        expect_word("run CH2", 32'h032A_BC00, 0, -1, 1'b0, 1'b0, 12'h0);
        expect_word("run CH5", 32'h0351_2300, 0, -1, 1'b0, 1'b0, 12'h0);
        seen = 1'b0;
        repeat (10) begin seen |= cmd_valid; tick(); end
        chk("no extra words after CH5", {31'h0, seen}, 32'h0);
        chk("idle busy after run", {31'h0, busy}, 32'h0);

        // Write colliding with acceptance forces a resend with the new code
        ch_wr_en = 1'b1; ch_wr_addr = 3'd3; ch_wr_data = 12'h111;
        tick();
        ch_wr_en = 1'b0;
        expect_word("coll first", 32'h0331_1100, 2, -1, 1'b0, 1'b1, 12'h222);
        expect_word("coll resend", 32'h0332_2200, 0, -1, 1'b0, 1'b0, 12'h0);
        seen = 1'b0;
        repeat (10) begin seen |= cmd_valid; tick(); end
        chk("no extra words after resend", {31'h0, seen}, 32'h0);

        // Randomized writes and backpressure against the model
        for (int i = 0; i < 8; i++) begin
            pend[i] = 1'b0; written[i] = 1'b0; mcode[i] = 12'h0; last_sent[i] = 12'h0;
        end
        model_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            cmd_ready  = ($urandom_range(0, 3) != 0);
            ch_wr_en   = ($urandom_range(0, 3) == 0);
            ch_wr_addr = 3'($urandom_range(0, 7));
            ch_wr_data = 12'($urandom);
            tick();
        end
        ch_wr_en  = 1'b0;
        cmd_ready = 1'b1;
        repeat (80) tick();
        model_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rand ch%0d drained", i), {31'h0, pend[i]}, 32'h0);
            if (written[i]) chk($sformatf("rand ch%0d final code", i), {20'h0, last_sent[i]}, {20'h0, mcode[i]});
        end
        chk("rand final cmd_valid", {31'h0, cmd_valid}, 32'h0);
        chk("rand final init_done", {31'h0, init_done}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
